// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin arbiter that lets NREQ requesters share one UART transmitter.
// A granted byte is written to the UART tx buffer, the arbiter waits for the
// UART tx-complete pending flag, clears it, and acknowledges the requester.
//
// Transfer sequence: IDLE -> WR -> WAIT -> ACK -> IDLE, so at most one byte
// is accepted every four cycles.
//
// Optional feature (compile-time macro UART_TX_ARB_TMO_EN):
//   When defined, a TMO_W-bit watchdog runs while in WAIT.  If it reaches
//   all-ones without the pending flag, the requester is acknowledged with
//   ack_err=1.  A pending flag in that same cycle wins, so ack_err=0.
//   When undefined, WAIT waits indefinitely and ack_err is tied low.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   TMO_W  timeout counter width
//
// Ports
//   sys_clk          clock, all state on the rising edge
//   sys_rst          synchronous active-high reset
//   uart_en          UART enable (uart_con[0]); low aborts and holds idle
//   req[NREQ]        per-requester level request, held until its ack
//   req_dat[8*NREQ]  byte of requester i at bits [8i+7:8i]
//   ack[NREQ]        one-cycle pulse: requester's byte sent or failed
//   ack_err          valid with ack: 1 = timeout, 0 = sent
//   uart_txbuf_wr    one-cycle write strobe into the UART tx buffer
//   uart_txbuf_wdat  byte presented with uart_txbuf_wr
//   uart_txpnd       UART tx-complete pending flag (level)
//   uart_txpnd_clr   one-cycle pulse clearing the UART pending flag
//   busy             high whenever the arbiter is not idle
//   gnt_id           index of the current or last granted requester
// -----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NREQ  = 4,
    parameter int TMO_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              uart_en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_dat,
    output logic [NREQ-1:0]   ack,
    output logic              ack_err,
    output logic              uart_txbuf_wr,
    output logic [7:0]        uart_txbuf_wdat,
    input  logic              uart_txpnd,
    output logic              uart_txpnd_clr,
    output logic              busy,
    output logic [2:0]        gnt_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [NREQ-1:0] ack_reg;
    logic            txbuf_wr_reg;
    logic [7:0]      txbuf_wdat_reg;
    logic            txpnd_clr_reg;
    logic            busy_reg;
    logic [2:0]      gnt_id_reg;
    logic [2:0]      last_gnt_reg;

    // Requests and bytes padded to the maximum of 8 requesters so that the
    // 3-bit grant index can address them directly for any legal NREQ.
    logic [7:0]      req_pad;
    logic [7:0]      req_byte [8];
    logic [NREQ-1:0] gnt_onehot;

    logic            win_found;
    logic [2:0]      win_idx;
    logic [3:0]      cand_sum;

    genvar gi;

    // An out-of-range parameter set shows up as this block in the elaborated
    // hierarchy; nothing in it drives logic.
    if (NREQ < 2 || NREQ > 8 || TMO_W < 1) begin : g_illegal_params
    end

    assign req_pad = 8'(req);

    for (gi = 0; gi < 8; gi++) begin : g_byte
        if (gi < NREQ) begin : g_used
            assign req_byte[gi] = req_dat[8*gi +: 8];
        end else begin : g_pad
            assign req_byte[gi] = 8'h00;
        end
    end

    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign gnt_onehot[gi] = (gnt_id_reg == 3'(gi));
    end

    // Round-robin search: first set request starting at last_gnt+1 and
    // wrapping past NREQ-1 back to 0.  last_gnt itself is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand_sum  = 4'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, last_gnt_reg} + 4'(k);
            if (cand_sum >= 4'(NREQ)) begin
                cand_sum = cand_sum - 4'(NREQ);
            end
            if (!win_found && req_pad[cand_sum[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[2:0];
            end
        end
    end

`ifdef UART_TX_ARB_TMO_EN
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             ack_err_reg;
    assign ack_err = ack_err_reg;
`else
    assign ack_err = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            ack_reg        <= '0;
            txbuf_wr_reg   <= 1'b0;
            txbuf_wdat_reg <= 8'h00;
            txpnd_clr_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            gnt_id_reg     <= 3'd0;
            // Last grant parked on the top requester so requester 0 wins first.
            last_gnt_reg   <= 3'(NREQ - 1);
`ifdef UART_TX_ARB_TMO_EN
            ack_err_reg    <= 1'b0;
            tmo_cnt_reg    <= '0;
`endif
        end else begin
            // Strobes default low; each is raised for exactly one cycle.
            ack_reg       <= '0;
            txbuf_wr_reg  <= 1'b0;
            txpnd_clr_reg <= 1'b0;
`ifdef UART_TX_ARB_TMO_EN
            ack_err_reg   <= 1'b0;
`endif
            if (!uart_en) begin
                // Abort: drop back to idle without ack or flag clear.  The
                // requester still holds req and is re-arbitrated later with
                // last_gnt unchanged, so it wins again.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (win_found) begin
                            state_reg      <= WR;
                            gnt_id_reg     <= win_idx;
                            txbuf_wdat_reg <= req_byte[win_idx];
                            txbuf_wr_reg   <= 1'b1;
                            busy_reg       <= 1'b1;
                        end
                    end
                    WR: begin
                        // The UART clears its pending flag on the write, so
                        // the flag is only looked at from WAIT onwards.
                        state_reg <= WAIT;
`ifdef UART_TX_ARB_TMO_EN
                        tmo_cnt_reg <= '0;
`endif
                    end
                    WAIT: begin
                        if (uart_txpnd) begin
                            state_reg     <= ACK;
                            ack_reg       <= gnt_onehot;
                            txpnd_clr_reg <= 1'b1;
                            last_gnt_reg  <= gnt_id_reg;
                        end
`ifdef UART_TX_ARB_TMO_EN
                        else if (tmo_cnt_reg == '1) begin
                            state_reg     <= ACK;
                            ack_reg       <= gnt_onehot;
                            txpnd_clr_reg <= 1'b1;
                            ack_err_reg   <= 1'b1;
                            last_gnt_reg  <= gnt_id_reg;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                        end
`endif
                    end
                    ACK: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ack             = ack_reg;
    assign uart_txbuf_wr   = txbuf_wr_reg;
    assign uart_txbuf_wdat = txbuf_wdat_reg;
    assign uart_txpnd_clr  = txpnd_clr_reg;
    assign busy            = busy_reg;
    assign gnt_id          = gnt_id_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed-plus-random bench for uart_tx_arb.  The reference model works at
// transaction level: a round-robin pick over the request vector, the byte
// table per requester, and the cycle on which the ack must appear given when
// the pending flag is returned (and, with UART_TX_ARB_TMO_EN, the timeout).
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NREQ  = 4;
    localparam int TMO_W = 4;
`ifdef UART_TX_ARB_TMO_EN
    // Ack edge (counted from the write edge) at which the timeout fires.
    localparam int TMO_AT = 2 + (1 << TMO_W) - 1;
`else
    localparam int TMO_AT = 1 << 30;
`endif

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              uart_en;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_dat;
    logic [NREQ-1:0]   ack;
    logic              ack_err;
    logic              uart_txbuf_wr;
    logic [7:0]        uart_txbuf_wdat;
    logic              uart_txpnd;
    logic              uart_txpnd_clr;
    logic              busy;
    logic [2:0]        gnt_id;

    logic [7:0]        dat_tb [NREQ];
    int                model_last;
    int                n_cmp = 0;
    int                n_err = 0;

    uart_tx_arb #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .uart_en         (uart_en),
        .req             (req),
        .req_dat         (req_dat),
        .ack             (ack),
        .ack_err         (ack_err),
        .uart_txbuf_wr   (uart_txbuf_wr),
        .uart_txbuf_wdat (uart_txbuf_wdat),
        .uart_txpnd      (uart_txpnd),
        .uart_txpnd_clr  (uart_txpnd_clr),
        .busy            (busy),
        .gnt_id          (gnt_id)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requester at or after last+1, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c = (last + k) % NREQ;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic pack_dat();
        for (int i = 0; i < NREQ; i++) req_dat[8*i +: 8] = dat_tb[i];
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ack"}, 32'(ack), 0);
        chk({tag, " wr"}, 32'(uart_txbuf_wr), 0);
        chk({tag, " clr"}, 32'(uart_txpnd_clr), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " err"}, 32'(ack_err), 0);
    endtask

    // One complete transfer, starting with the DUT idle and req already set.
    // pend      : number of cycles after the write edge before txpnd is raised
    // drop_mode : 0 keep req, 1 drop on ack, 2 drop right after the grant
    task automatic xfer(input int pend, input int drop_mode, input string tag);
        int              win;
        int              ack_at;
        logic            exp_err;
        logic [NREQ-1:0] onehot;
        win    = rr_pick(req, model_last);
        onehot = '0;
        onehot[win] = 1'b1;
        // Flag is only sampled in WAIT, i.e. from the second edge after the write.
        ack_at  = (pend + 1 < 2) ? 2 : pend + 1;
        exp_err = 1'b0;
        if (ack_at > TMO_AT) begin
            ack_at  = TMO_AT;
            exp_err = 1'b1;
        end
        step();
        chk({tag, " wr"}, 32'(uart_txbuf_wr), 1);
        chk({tag, " wdat"}, 32'(uart_txbuf_wdat), 32'(dat_tb[win]));
        chk({tag, " gnt"}, 32'(gnt_id), 32'(win));
        chk({tag, " busy"}, 32'(busy), 1);
        chk({tag, " ack@wr"}, 32'(ack), 0);
        if (drop_mode == 2) req[win] = 1'b0;
        for (int c = 1; c <= ack_at; c++) begin
            if (c - 1 == pend) uart_txpnd = 1'b1;
            step();
            if (c < ack_at) begin
                chk({tag, " ack early"}, 32'(ack), 0);
                chk({tag, " wr again"}, 32'(uart_txbuf_wr), 0);
                chk({tag, " gnt hold"}, 32'(gnt_id), 32'(win));
                chk({tag, " busy wait"}, 32'(busy), 1);
            end else begin
                chk({tag, " ack"}, 32'(ack), 32'(onehot));
                chk({tag, " clr"}, 32'(uart_txpnd_clr), 1);
                chk({tag, " ack_err"}, 32'(ack_err), 32'(exp_err));
                chk({tag, " wr@ack"}, 32'(uart_txbuf_wr), 0);
            end
        end
        uart_txpnd = 1'b0;
        if (drop_mode == 1) req[win] = 1'b0;
        model_last = win;
        step();
        chk({tag, " ack end"}, 32'(ack), 0);
        chk({tag, " clr end"}, 32'(uart_txpnd_clr), 0);
        chk({tag, " busy end"}, 32'(busy), 0);
        $display("xfer %s: gnt=%0d byte=%02h pend=%0d ack_cycle=%0d err=%0b",
                 tag, win, dat_tb[win], pend, ack_at, exp_err);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        chk_quiet("reset");
        chk("reset wdat", 32'(uart_txbuf_wdat), 0);
        chk("reset gnt", 32'(gnt_id), 0);
        sys_rst    = 1'b0;
        model_last = NREQ - 1;
        $display("reset applied");
    endtask

    initial begin
        int              win;
        logic [NREQ-1:0] newbits;

        sys_rst    = 1'b1;
        uart_en    = 1'b0;
        req        = '0;
        uart_txpnd = 1'b0;
        for (int i = 0; i < NREQ; i++) dat_tb[i] = 8'($urandom);
        pack_dat();
        step();
        do_reset();
        uart_en = 1'b1;

        // Pending flag with no request is ignored while idle.
        uart_txpnd = 1'b1;
        step();
        step();
        chk_quiet("idle txpnd");
        uart_txpnd = 1'b0;
        $display("idle with stale txpnd checked");

        // Single request, byte A5 from requester 2, flag after 10 cycles.
        dat_tb[2] = 8'hA5;
        pack_dat();
        req = 4'b0100;
        xfer(10, 1, "single");

        // Round-robin from reset with all requests held: 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) xfer(3, 0, "rr");
        req = '0;
        step();

        // Abort in WAIT, then re-arbitration on enable return.
        for (int i = 0; i < NREQ; i++) dat_tb[i] = 8'($urandom);
        pack_dat();
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        win = rr_pick(req, model_last);
        step();
        chk("abort wr", 32'(uart_txbuf_wr), 1);
        chk("abort gnt", 32'(gnt_id), 32'(win));
        step();
        chk("abort busy wait", 32'(busy), 1);
        uart_en = 1'b0;
        step();
        chk_quiet("abort");
        step();
        chk_quiet("abort hold");
        $display("abort: gnt=%0d dropped in WAIT", win);
        uart_en = 1'b1;
        xfer(2, 1, "rearb");
        req = '0;
        step();

        // Requester withdraws right after its grant; the ack is still issued.
        dat_tb[1] = 8'($urandom);
        pack_dat();
        req = 4'b0010;
        xfer(4, 2, "drop");

        // Random request mixes and pending-flag delays.
        for (int n = 0; n < 10; n++) begin
            newbits = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) dat_tb[i] = 8'($urandom);
            end
            pack_dat();
            req = req | newbits;
            xfer(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), "rand");
        end
        req = '0;
        step();

`ifdef UART_TX_ARB_TMO_EN
        // Timeout: no flag at all, flag on the final count, flag one earlier.
        dat_tb[3] = 8'($urandom);
        pack_dat();
        req = 4'b1000;
        xfer(1000, 0, "tmo");
        xfer(TMO_AT - 1, 0, "tmo_last");
        xfer(TMO_AT - 2, 1, "tmo_early");
        req = '0;
        step();
`endif

        // Reset in WAIT abandons the transfer; requester 0 wins afterwards.
        req = 4'b0010;
        xfer(2, 1, "pre_rst");
        req = 4'b1111;
        win = rr_pick(req, model_last);
        step();
        chk("midrst wr", 32'(uart_txbuf_wr), 1);
        chk("midrst gnt", 32'(gnt_id), 32'(win));
        step();
        step();
        do_reset();
        xfer(3, 1, "post_rst");
        req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, 4, number of requesters; legal 2..8.
REQ-002 Parameter TMO_W, 16, timeout counter width.
REQ-003 sys_clk  input  1  single clock; all state on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 uart_en  input  1  UART enable, from uart_con[0]; low aborts and holds the arbiter idle.
REQ-006 req  input  NREQ  per-requester level request; held until the matching ack.
REQ-007 req_dat  input  8*NREQ  byte for requester i at bits [8i+7:8i]; stable while req[i] is high.
REQ-008 ack  output  NREQ  one-cycle pulse; byte of requester i has been sent or has failed.
REQ-009 ack_err  output  1  valid with ack; 1 means timeout, 0 means sent.
REQ-010 uart_txbuf_wr  output  1  one-cycle write strobe to the UART tx buffer.
REQ-011 uart_txbuf_wdat  output  8  byte presented with uart_txbuf_wr.
REQ-012 uart_txpnd  input  1  UART tx-complete pending flag, level.
REQ-013 uart_txpnd_clr  output  1  one-cycle pulse that clears the UART tx pending flag.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 gnt_id  output  3  index of the current or last granted requester.

Function
REQ-016 FSM states: IDLE, WR, WAIT, ACK.
REQ-017 IDLE -> WR when uart_en=1 and req!=0.
  - Winner is chosen round-robin: first set bit searching upward from last_gnt+1, wrapping at NREQ-1 to 0.
  - On that edge req_dat of the winner is latched and gnt_id is updated.
REQ-018 WR: uart_txbuf_wr=1 and uart_txbuf_wdat=latched byte for exactly this cycle; next state is WAIT.
REQ-019 Latency: req seen in IDLE at edge N -> uart_txbuf_wr high in cycle N+1.
REQ-020 WAIT -> ACK when uart_txpnd=1; ack_err for this byte is 0.
REQ-021 ACK, held for one cycle, then next state is IDLE:
  - ack[gnt_id]=1 and uart_txpnd_clr=1;
  - last_gnt is set to gnt_id.
REQ-022 uart_txpnd is ignored in IDLE, WR and ACK.
  - A pending flag left stale from WR is not sampled until WAIT.
  - The UART clears the flag on txbuf_wr.
REQ-023 uart_en=0 in any state forces IDLE on the next edge.
  - No ack, no txpnd_clr; last_gnt is unchanged.
  - Requester keeps req high and is re-arbitrated when uart_en returns.
REQ-024 A requester that drops req while granted does not affect the transfer.
  - The ack is still issued; the requester ignores it.
REQ-025 New requests arriving during WR/WAIT/ACK wait for the next IDLE.
  - No grant is issued back-to-back faster than one byte per 4 cycles minimum (IDLE->WR->WAIT->ACK).
REQ-026 Only one bit of ack is ever high at a time.
  - ack and uart_txbuf_wr are never high in the same cycle.
REQ-027 All outputs are registered.

Reset
REQ-028 When sys_rst=1 at an edge, on that edge:
  - state=IDLE;
  - ack=0, ack_err=0, uart_txbuf_wr=0, uart_txbuf_wdat=0, uart_txpnd_clr=0, busy=0;
  - gnt_id=0, last_gnt=NREQ-1 (so requester 0 wins first), timeout counter=0.
REQ-029 Reset while in WR/WAIT/ACK abandons the transfer; no ack is issued.

Configuration
REQ-030 Macro UART_TX_ARB_TMO_EN, when defined:
  - a TMO_W-bit counter clears on entry to WAIT and increments each cycle in WAIT;
  - when it equals all-ones with uart_txpnd=0, the next state is ACK with ack_err=1;
  - uart_txpnd=1 in the same cycle takes precedence (ack_err=0).
REQ-031 Macro UART_TX_ARB_TMO_EN not defined:
  - no counter; WAIT waits indefinitely for uart_txpnd;
  - ack_err is tied 0.

Verification
REQ-032 Single request: reset, uart_en=1, req=4'b0100, dat2=8'hA5.
  - uart_txbuf_wr one cycle later with wdat=8'hA5, gnt_id=2.
  - Assert txpnd 10 cycles later -> ack=4'b0100 and txpnd_clr on the cycle after WAIT samples it, ack_err=0.
REQ-033 Round-robin: req=4'b1111 held, txpnd returned 3 cycles after each write.
  - Grant order is 0,1,2,3,0; each ack one-hot.
REQ-034 Abort: drop uart_en in WAIT.
  - IDLE next cycle, no ack.
  - Restore uart_en with req still high -> same requester re-granted, byte rewritten.
REQ-035 Timeout (macro defined, TMO_W=4): never assert txpnd.
  - ack with ack_err=1 exactly 16 cycles after entering WAIT.
  - Repeat with txpnd arriving on the final count -> ack_err=0.
REQ-036 Reset mid-transfer: assert sys_rst in WAIT.
  - All outputs 0 next cycle.
  - Next grant goes to requester 0 even if requester 3 was last.
